// File: rtl/new_usb_dma_mc.sv
// new_usb_dma_mc: round-robin multi-channel read DMA, single-beat reads in, tagged words out to the packet FIFO.
// Define NEWUSB_DMA_RESP_CHECK_EN to report non-OKAY read responses on done_err_o.
module new_usb_dma_mc #(
    parameter int NumChannels    = 4,
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int TFLenWidth     = 8,
    parameter int MaxOutstanding = 2,
    localparam int ChanWidth     = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumChannels*AddrWidth-1:0]  req_addr_i,
    input  logic [NumChannels*TFLenWidth-1:0] req_len_i,
    input  logic [NumChannels-1:0]            req_valid_i,
    output logic [NumChannels-1:0]            req_ready_o,
    output logic [NumChannels-1:0]            done_o,
    output logic                              done_err_o,
    output logic [AddrWidth-1:0]              ar_addr_o,
    output logic                              ar_valid_o,
    input  logic                              ar_ready_i,
    input  logic [DataWidth-1:0]              r_data_i,
    input  logic [1:0]                        r_resp_i,
    input  logic                              r_valid_i,
    output logic                              r_ready_o,
    output logic [DataWidth-1:0]              fifo_data_o,
    output logic [DataWidth/8-1:0]            fifo_strb_o,
    output logic [ChanWidth-1:0]              fifo_chan_o,
    output logic                              fifo_last_o,
    output logic                              fifo_valid_o,
    input  logic                              fifo_ready_i,
    output logic                              busy_o
);
    localparam int S   = DataWidth / 8;
    localparam int LS  = $clog2(S);
    localparam int LS1 = LS + 1;
    localparam int WW  = TFLenWidth + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [ChanWidth-1:0] last_grant_q, chan_q, grant_idx, out_chan_q;
    logic                 grant_hit;
    logic [AddrWidth-1:0] ar_addr_q, sel_addr;
    logic [TFLenWidth-1:0] sel_len;
    logic [LS-1:0]        off_q, sel_off, sel_end_m1;
    logic [LS:0]          lend_q, sel_lend;
    logic [WW-1:0]        sel_sum, sel_words, words_q, ar_left_q, r_cnt_q;
    logic [3:0]           outst_q;
    logic                 ar_hs, r_hs, fifo_pop;
    logic [DataWidth-1:0] data_q;
    logic [S-1:0]         strb_q, beat_strb, mask_first, mask_last;
    logic                 last_q, valid_q, beat_first, beat_last;

    // Round-robin search starts one above the previously granted channel.
    always_comb begin
        int idx;
        idx       = 0;
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NumChannels; i++) begin
            idx = (int'(last_grant_q) + 1 + i) % NumChannels;
            if (!grant_hit && req_valid_i[idx]) begin
                grant_hit = 1'b1;
                grant_idx = ChanWidth'(idx);
            end
        end
    end

    always_comb begin
        sel_addr   = req_addr_i[int'(grant_idx)*AddrWidth +: AddrWidth];
        sel_len    = req_len_i[int'(grant_idx)*TFLenWidth +: TFLenWidth];
        sel_off    = sel_addr[LS-1:0];
        sel_sum    = WW'(sel_off) + WW'(sel_len);
        sel_words  = (sel_sum >> LS) + WW'(|sel_sum[LS-1:0]);
        // Truncation to LS bits gives (offset+len-1) mod S.
        sel_end_m1 = sel_off + sel_len[LS-1:0] - LS'(1);
        sel_lend   = {1'b0, sel_end_m1} + LS1'(1);
    end

    always_comb begin
        mask_first = {S{1'b1}} << off_q;
        mask_last  = {S{1'b1}} >> (LS1'(S) - lend_q);
        beat_first = (r_cnt_q == '0);
        beat_last  = (r_cnt_q == words_q - WW'(1));
        beat_strb  = {S{1'b1}};
        if (beat_first) beat_strb = beat_strb & mask_first;
        if (beat_last)  beat_strb = beat_strb & mask_last;
    end

    assign ar_valid_o = (state_q == ISSUE) && (ar_left_q != '0) && (outst_q < 4'(MaxOutstanding));
    assign ar_addr_o  = ar_addr_q;
    assign r_ready_o  = !valid_q || fifo_ready_i;
    assign ar_hs      = ar_valid_o && ar_ready_i;
    assign r_hs       = r_valid_i && r_ready_o;
    assign fifo_pop   = valid_q && fifo_ready_i;
    assign busy_o     = (state_q != IDLE) || valid_q;

    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        done_o      = '0;
        case (state_q)
            IDLE: if (grant_hit) begin
                req_ready_o = NumChannels'(1) << grant_idx;
                state_d     = (sel_len == '0) ? DONE : ISSUE;
            end
            ISSUE: if (ar_hs && ar_left_q == WW'(1)) state_d = DRAIN;
            DRAIN: if (fifo_pop && last_q) state_d = DONE;
            DONE: begin
                done_o  = NumChannels'(1) << chan_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= ChanWidth'(NumChannels - 1);
            chan_q       <= '0;
            ar_addr_q    <= '0;
            off_q        <= '0;
            lend_q       <= '0;
            words_q      <= '0;
            ar_left_q    <= '0;
            r_cnt_q      <= '0;
            outst_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_hit) begin
                last_grant_q <= grant_idx;
                chan_q       <= grant_idx;
                ar_addr_q    <= sel_addr & ~AddrWidth'(S - 1);
                off_q        <= sel_off;
                lend_q       <= sel_lend;
                words_q      <= sel_words;
                ar_left_q    <= sel_words;
                r_cnt_q      <= '0;
            end else begin
                if (ar_hs) begin
                    ar_addr_q <= ar_addr_q + AddrWidth'(S);
                    ar_left_q <= ar_left_q - WW'(1);
                end
                if (r_hs) r_cnt_q <= r_cnt_q + WW'(1);
            end
            case ({ar_hs, r_hs})
                2'b10:   outst_q <= outst_q + 4'd1;
                2'b01:   outst_q <= outst_q - 4'd1;
                default: outst_q <= outst_q;
            endcase
        end
    end

    // One-entry output register; refilled in the same cycle it drains.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            strb_q     <= '0;
            last_q     <= 1'b0;
            out_chan_q <= '0;
        end else if (r_hs) begin
            valid_q    <= 1'b1;
            data_q     <= r_data_i;
            strb_q     <= beat_strb;
            last_q     <= beat_last;
            out_chan_q <= chan_q;
        end else if (fifo_pop) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign fifo_valid_o = valid_q;
    assign fifo_data_o  = data_q;
    assign fifo_strb_o  = strb_q;
    assign fifo_last_o  = last_q;
    assign fifo_chan_o  = out_chan_q;

`ifdef NEWUSB_DMA_RESP_CHECK_EN
    logic err_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                           err_q <= 1'b0;
        else if (state_q == IDLE)            err_q <= 1'b0;
        else if (r_hs && r_resp_i != 2'b00)  err_q <= 1'b1;
    end
    assign done_err_o = (state_q == DONE) && err_q;
`else
    logic unused_resp;
    assign unused_resp = ^r_resp_i;
    assign done_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_new_usb_dma_mc.sv
// Bench for new_usb_dma_mc: byte-range reference model, randomized read slave and FIFO sink.
module tb_new_usb_dma_mc;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TL = 8;
  localparam int MO = 2;
  localparam int W  = 39;

  logic clk = 1'b0;
  logic rst;
  logic [N*AW-1:0] req_addr_i;
  logic [N*TL-1:0] req_len_i;
  logic [N-1:0] req_valid_i, req_ready_o, done_o;
  logic done_err_o, ar_valid_o, ar_ready_i, r_valid_i, r_ready_o;
  logic [AW-1:0] ar_addr_o;
  logic [DW-1:0] r_data_i, fifo_data_o;
  logic [1:0] r_resp_i, fifo_chan_o;
  logic [3:0] fifo_strb_o;
  logic fifo_last_o, fifo_valid_o, fifo_ready_i, busy_o;

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  new_usb_dma_mc #(.NumChannels(N), .DataWidth(DW), .AddrWidth(AW), .TFLenWidth(TL),
                   .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_i(rst), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .done_o(done_o),
    .done_err_o(done_err_o), .ar_addr_o(ar_addr_o), .ar_valid_o(ar_valid_o),
    .ar_ready_i(ar_ready_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .fifo_data_o(fifo_data_o),
    .fifo_strb_o(fifo_strb_o), .fifo_chan_o(fifo_chan_o), .fifo_last_o(fifo_last_o),
    .fifo_valid_o(fifo_valid_o), .fifo_ready_i(fifo_ready_i), .busy_o(busy_o));

  // scoreboard state
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_ar_q[$];
  logic [N:0]    exp_done_q[$];
  int checks = 0;
  int errors = 0;

  bit ar_rand = 0, fifo_rand = 0, stall = 0;
  int r_delay = 1;
  logic [AW-1:0] bad_addr = 32'hFFFF_FFFF;
  logic [AW-1:0] ch_addr[N];
  logic [TL-1:0] ch_len[N];
  bit clr[N];
  int glog_chan[$], glog_cyc[$], dlog_cyc[$];
  logic [3:0] got_strb_q[$];
  int last_event_cyc = 0, outst = 0, max_outst = 0, ar_valid_cnt = 0, delivered = 0, last_t = 0;
  int pend_t[$];
  logic [AW-1:0] pend_a[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Reference: every aligned word touching [addr, addr+len) is read; a byte is
  // strobed exactly when its address falls inside that range.
  function automatic void model_push(input int c);
    longint lo, hi, wa;
    logic [3:0] s;
    logic [N-1:0] oh;
    logic e;
    bit lst;
    lo = longint'(ch_addr[c]);
    hi = lo + longint'(ch_len[c]);
    wa = lo - (lo % 4);
    e = 1'b0;
    while (wa < hi) begin
      for (int b = 0; b < 4; b++) s[b] = (wa + b >= lo) && (wa + b < hi);
      lst = (wa + 4 >= hi);
      exp_ar_q.push_back(AW'(wa));
      exp_q.push_back({2'(c), lst, s, mem_word(AW'(wa))});
      if (AW'(wa) == bad_addr) e = 1'b1;
      wa += 4;
    end
`ifndef NEWUSB_DMA_RESP_CHECK_EN
    e = 1'b0;
`endif
    oh = '0;
    oh[c] = 1'b1;
    exp_done_q.push_back({oh, e});
  endfunction

  // driver tasks
  task automatic set_req(input int c, input logic [AW-1:0] a, input logic [TL-1:0] l);
    ch_addr[c] = a;
    ch_len[c] = l;
    req_addr_i[c*AW +: AW] = a;
    req_len_i[c*TL +: TL] = l;
    req_valid_i[c] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid_i = '0;
    for (int c = 0; c < N; c++) clr[c] = 0;
    exp_q.delete(); exp_ar_q.delete(); exp_done_q.delete();
    pend_t.delete(); pend_a.delete();
    outst = 0; last_t = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (n < budget && !(exp_q.size() == 0 && exp_ar_q.size() == 0 &&
               exp_done_q.size() == 0 && req_valid_i == '0 && !busy_o));
    check({tag, "_timeout"}, n < budget, 1);
  endtask

  // request handshake monitor: logs grants, feeds the model, drops valid afterwards
  always begin : grant_mon
    @(negedge clk);
    for (int c = 0; c < N; c++) if (clr[c]) begin req_valid_i[c] = 1'b0; clr[c] = 0; end
    #1;
    if (!rst && req_ready_o != '0) begin
      check("grant_onehot", $countones(req_ready_o), 1);
      for (int c = 0; c < N; c++) if (req_ready_o[c]) begin
        glog_chan.push_back(c);
        glog_cyc.push_back(cyc);
        model_push(c);
        clr[c] = 1;
        if (ch_len[c] == '0) last_event_cyc = cyc;
      end
    end
  end

  // read slave: in-order responses after r_delay cycles
  always begin : slave
    logic [AW-1:0] e;
    int t;
    @(negedge clk);
    ar_ready_i = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
      r_valid_i = 1'b1;
      r_data_i  = mem_word(pend_a[0]);
      r_resp_i  = (pend_a[0] == bad_addr) ? 2'b10 : 2'b00;
    end else begin
      r_valid_i = 1'b0;
      r_data_i  = '0;
      r_resp_i  = 2'b00;
    end
    #1;
    if (!rst) begin
      if (ar_valid_o) ar_valid_cnt++;
      if (ar_valid_o && ar_ready_i) begin
        e = 'x;
        if (exp_ar_q.size() > 0) e = exp_ar_q.pop_front();
        check("ar_addr", ar_addr_o, e);
        t = cyc + r_delay + (ar_rand ? int'($urandom_range(0, 2)) : 0);
        if (t < last_t) t = last_t;
        last_t = t;
        pend_t.push_back(t);
        pend_a.push_back(ar_addr_o);
        outst++;
      end
      if (r_valid_i && r_ready_o) begin
        void'(pend_t.pop_front());
        void'(pend_a.pop_front());
        outst--;
      end
      if (outst > max_outst) max_outst = outst;
    end
  end

  // FIFO sink: compares each word and checks stability while stalled
  always begin : sink
    logic [W-1:0] got, e, hold_word;
    logic hold_prev;
    @(negedge clk);
    fifo_ready_i = stall ? 1'b0 : (fifo_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    got = {fifo_chan_o, fifo_last_o, fifo_strb_o, fifo_data_o};
    if (!rst) begin
      if (hold_prev === 1'b1) begin
        check("fifo_hold_valid", fifo_valid_o, 1);
        check("fifo_hold_word", got, hold_word);
      end
      if (fifo_valid_o && fifo_ready_i) begin
        e = 'x;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check("fifo_word", got, e);
        got_strb_q.push_back(fifo_strb_o);
        delivered++;
        if (fifo_last_o) last_event_cyc = cyc;
      end
      hold_prev = fifo_valid_o && !fifo_ready_i;
      hold_word = got;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // completion monitor
  always begin : done_mon
    logic [N:0] e;
    @(negedge clk); #1;
    if (!rst && done_o != '0) begin
      e = 'x;
      if (exp_done_q.size() > 0) e = exp_done_q.pop_front();
      check("done_chan", done_o, e[N:1]);
      check("done_err", done_err_o, e[0]);
      check("done_latency", cyc, last_event_cyc + 1);
      dlog_cyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, d0, n;
    rst = 1'b1;
    req_valid_i = '0; req_addr_i = '0; req_len_i = '0;
    ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0; r_resp_i = 2'b00; fifo_ready_i = 1'b1;
    for (int c = 0; c < N; c++) begin ch_addr[c] = '0; ch_len[c] = '0; clr[c] = 0; end

    // reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready_o, 0);
    check("rst_done", done_o, 0);
    check("rst_done_err", done_err_o, 0);
    check("rst_ar_valid", ar_valid_o, 0);
    check("rst_fifo_valid", fifo_valid_o, 0);
    check("rst_fifo_last", fifo_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ar_addr", ar_addr_o, 0);
    check("rst_fifo_data", fifo_data_o, 0);
    check("rst_fifo_strb", fifo_strb_o, 0);
    check("rst_fifo_chan", fifo_chan_o, 0);
    check("rst_r_ready", r_ready_o, 1);
    @(negedge clk);
    rst = 1'b0;

    // unaligned 5-byte fetch
    @(negedge clk);
    got_strb_q.delete();
    set_req(0, 32'h1002, 5);
    wait_idle(200, "t1");
    check("t1_words", got_strb_q.size(), 2);
    check("t1_strb0", got_strb_q[0], 4'b1100);
    check("t1_strb1", got_strb_q[1], 4'b0111);

    // outstanding limit with slow responses
    r_delay = 3; max_outst = 0; delivered = 0; got_strb_q.delete(); d0 = dlog_cyc.size();
    @(negedge clk);
    set_req(0, 32'h2000, 16);
    wait_idle(300, "t2");
    check("t2_max_outst", max_outst, 2);
    check("t2_words", delivered, 4);
    check("t2_strb_all", {got_strb_q[0], got_strb_q[1], got_strb_q[2], got_strb_q[3]}, 16'hFFFF);
    check("t2_done_pulses", dlog_cyc.size() - d0, 1);

    // round-robin order after reset
    r_delay = 1;
    do_reset();
    glog_chan.delete(); glog_cyc.delete();
    @(negedge clk);
    set_req(1, 32'h4000, 12);
    set_req(3, 32'h5001, 8);
    n = 0;
    do begin @(negedge clk); #2; n++; end while (glog_chan.size() < 2 && n < 300);
    check("t3_grant_wait", n < 300, 1);
    @(negedge clk);
    set_req(1, 32'h4100, 4);
    set_req(2, 32'h6002, 3);
    wait_idle(400, "t3");
    check("t3_grants", glog_chan.size(), 4);
    check("t3_order", {8'(glog_chan[0]), 8'(glog_chan[1]), 8'(glog_chan[2]), 8'(glog_chan[3])},
          32'h01030102);

    // zero-length request
    c0 = ar_valid_cnt;
    @(negedge clk);
    set_req(2, 32'h7000, 0);
    wait_idle(100, "t4");
    check("t4_no_ar", ar_valid_cnt, c0);
    check("t4_done_after_grant", dlog_cyc[$], glog_cyc[$] + 1);

    // downstream stall mid-transfer
    delivered = 0;
    @(negedge clk);
    set_req(3, 32'h8000, 40);
    n = 0;
    do begin @(negedge clk); #2; n++; end while (delivered < 3 && n < 300);
    check("t5_start_wait", n < 300, 1);
    stall = 1;
    repeat (3) @(negedge clk);
    #2;
    check("t5_stall_valid", fifo_valid_o, 1);
    check("t5_stall_r_ready", r_ready_o, 0);
    repeat (7) @(negedge clk);
    stall = 0;
    wait_idle(300, "t5");
    check("t5_words", delivered, 10);

    // error response on the middle beat
    delivered = 0;
    bad_addr = 32'h3004;
    @(negedge clk);
    set_req(0, 32'h3000, 12);
    wait_idle(200, "t6");
    check("t6_words", delivered, 3);
    bad_addr = 32'hFFFF_FFFF;

    // randomized traffic
    max_outst = 0;
    for (int k = 0; k < 16; k++) begin
      ar_rand = 1'($urandom_range(0, 1));
      fifo_rand = 1'($urandom_range(0, 1));
      r_delay = $urandom_range(1, 4);
      @(negedge clk);
      set_req($urandom_range(0, N - 1), AW'($urandom_range(0, 16'hFFFF)), TL'($urandom_range(0, 40)));
      wait_idle(600, "rand");
    end
    check("rand_max_outst", max_outst <= MO, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
